// File: rtl/id_stage.sv
// RV32I decode stage: register file with write-back bypass, immediate generation,
// control decode and load-use hazard detection, feeding a registered ID/EX bundle.
module id_stage #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] order_data,
  input  logic [XLEN-1:0] pc_in_data,
  input  logic [XLEN-1:0] plusFour_in_data,
  input  logic            flush,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic            id_valid,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic            funct7b5,
  output logic            alu_src,
  output logic            mem_read,
  output logic            mem_write,
  output logic            reg_write,
  output logic            branch,
  output logic            jump,
  output logic [1:0]      wb_sel,
  output logic [XLEN-1:0] pc_out_data,
  output logic [XLEN-1:0] plusFour_out_data,
  output logic            illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  function automatic logic signed [XLEN-1:0] imm_i(input logic [XLEN-1:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic signed [XLEN-1:0] imm_s(input logic [XLEN-1:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic signed [XLEN-1:0] imm_b(input logic [XLEN-1:0] ins);
    return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic signed [XLEN-1:0] imm_j(input logic [XLEN-1:0] ins);
    return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  function automatic logic signed [XLEN-1:0] imm_u(input logic [XLEN-1:0] ins);
    return {ins[31:12], 12'b0};
  endfunction

  logic [6:0] opcode;
  logic [4:0] rs1_idx, rs2_idx;
  assign opcode  = order_data[6:0];
  assign rs1_idx = order_data[19:15];
  assign rs2_idx = order_data[24:20];

  // Register file; a same-cycle write-back is forwarded to the read ports.
  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] rs1_val, rs2_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wb_we && wb_rd != 5'd0) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  assign rs1_val = (rs1_idx == 5'd0) ? '0 :
                   (wb_we && wb_rd == rs1_idx) ? wb_data : regs_q[rs1_idx];
  assign rs2_val = (rs2_idx == 5'd0) ? '0 :
                   (wb_we && wb_rd == rs2_idx) ? wb_data : regs_q[rs2_idx];

  logic            legal, uses_rs1, uses_rs2;
  logic            alu_src_d, mem_read_d, mem_write_d, reg_write_d, branch_d, jump_d;
  logic [1:0]      wb_sel_d;
  logic [XLEN-1:0] imm_d;

  always_comb begin
    legal       = 1'b1;
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    alu_src_d   = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    reg_write_d = 1'b1;
    branch_d    = 1'b0;
    jump_d      = 1'b0;
    wb_sel_d    = 2'd0;
    imm_d       = '0;
    case (opcode)
      OP_R:      begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_IMM:    begin uses_rs1 = 1'b1; alu_src_d = 1'b1; imm_d = imm_i(order_data); end
      OP_LOAD:   begin
        uses_rs1 = 1'b1; alu_src_d = 1'b1; mem_read_d = 1'b1; wb_sel_d = 2'd1;
        imm_d = imm_i(order_data);
      end
      OP_STORE:  begin
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; alu_src_d = 1'b1; mem_write_d = 1'b1;
        reg_write_d = 1'b0; imm_d = imm_s(order_data);
      end
      OP_BRANCH: begin
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; branch_d = 1'b1; reg_write_d = 1'b0;
        imm_d = imm_b(order_data);
      end
      OP_JAL:    begin jump_d = 1'b1; wb_sel_d = 2'd2; imm_d = imm_j(order_data); end
      OP_JALR:   begin
        uses_rs1 = 1'b1; jump_d = 1'b1; alu_src_d = 1'b1; wb_sel_d = 2'd2;
        imm_d = imm_i(order_data);
      end
      OP_LUI, OP_AUIPC: imm_d = imm_u(order_data);
      default:   begin legal = 1'b0; reg_write_d = 1'b0; end
    endcase
  end

  // A load in EX whose destination this instruction reads must stall one cycle.
  logic hazard, live;
  assign hazard = ex_mem_read && (ex_rd != 5'd0) &&
                  ((uses_rs1 && ex_rd == rs1_idx) || (uses_rs2 && ex_rd == rs2_idx));
  assign stall  = hazard && !flush && !rst;
  assign live   = legal && !flush && !hazard;

  logic            id_valid_q, illegal_q;
  logic [7:0]      ctrl_q;
  logic [XLEN-1:0] rs1_data_q, rs2_data_q, imm_q, pc_q, plus4_q;
  logic [4:0]      rd_q, rs1_q, rs2_q;
  logic [2:0]      funct3_q;
  logic            funct7b5_q;

  // ID/EX boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      ctrl_q     <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      plus4_q    <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
    end else begin
      id_valid_q <= live;
      illegal_q  <= !legal && !flush;
      ctrl_q     <= live ? {alu_src_d, mem_read_d, mem_write_d, reg_write_d,
                            branch_d, jump_d, wb_sel_d} : 8'd0;
      rs1_data_q <= rs1_val;
      rs2_data_q <= rs2_val;
      imm_q      <= imm_d;
      pc_q       <= pc_in_data;
      plus4_q    <= plusFour_in_data;
      rd_q       <= order_data[11:7];
      rs1_q      <= rs1_idx;
      rs2_q      <= rs2_idx;
      funct3_q   <= order_data[14:12];
      funct7b5_q <= order_data[30];
    end
  end

  assign id_valid          = id_valid_q;
  assign illegal           = illegal_q;
  assign {alu_src, mem_read, mem_write, reg_write, branch, jump, wb_sel} = ctrl_q;
  assign rs1_data          = rs1_data_q;
  assign rs2_data          = rs2_data_q;
  assign imm               = imm_q;
  assign pc_out_data       = pc_q;
  assign plusFour_out_data = plus4_q;
  assign rd                = rd_q;
  assign rs1               = rs1_q;
  assign rs2               = rs2_q;
  assign funct3            = funct3_q;
  assign funct7b5          = funct7b5_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed cases then random instruction streams, all compared
// against an opcode-table reference model with its own register file.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] order_data, pc_in_data, plusFour_in_data;
  logic        flush, ex_mem_read, wb_we;
  logic [4:0]  ex_rd, wb_rd;
  logic [31:0] wb_data;
  logic        stall, id_valid;
  logic [31:0] rs1_data, rs2_data, imm, pc_out_data, plusFour_out_data;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        funct7b5, alu_src, mem_read, mem_write, reg_write, branch, jump, illegal;
  logic [1:0]  wb_sel;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .order_data(order_data), .pc_in_data(pc_in_data),
    .plusFour_in_data(plusFour_in_data), .flush(flush), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
    .id_valid(id_valid), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rd(rd),
    .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7b5(funct7b5), .alu_src(alu_src),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .branch(branch),
    .jump(jump), .wb_sel(wb_sel), .pc_out_data(pc_out_data),
    .plusFour_out_data(plusFour_out_data), .illegal(illegal)
  );

  logic [7:0] ctrl_obs;
  assign ctrl_obs = {alu_src, mem_read, mem_write, reg_write, branch, jump, wb_sel};

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] mregs [32];
  logic        exp_stall, stall_seen;

  // legal, reads rs1, reads rs2, ctrl {alu_src,mem_rd,mem_wr,reg_wr,br,jmp,wb_sel}, imm
  typedef struct packed {
    logic        legal, u1, u2;
    logic [7:0]  ctrl;
    logic [31:0] imm;
  } ref_t;

  function automatic ref_t ref_decode(input logic [31:0] ins);
    logic signed [31:0] s;
    logic [31:0] iI, iS, iB, iJ, iU;
    ref_t r;
    s  = ins;
    iI = 32'(s >>> 20);
    iS = 32'((s >>> 25) <<< 5) | {27'd0, ins[11:7]};
    iB = 32'((s >>> 31) <<< 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5)
         | (32'(ins[11:8]) << 1);
    iJ = 32'((s >>> 31) <<< 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11)
         | (32'(ins[30:21]) << 1);
    iU = ins & 32'hFFFF_F000;
    case (ins[6:0])
      7'h33:   r = {3'b111, 8'b0001_0000, 32'd0};
      7'h13:   r = {3'b110, 8'b1001_0000, iI};
      7'h03:   r = {3'b110, 8'b1101_0001, iI};
      7'h23:   r = {3'b111, 8'b1010_0000, iS};
      7'h63:   r = {3'b111, 8'b0000_1000, iB};
      7'h6F:   r = {3'b100, 8'b0001_0110, iJ};
      7'h67:   r = {3'b110, 8'b1001_0110, iI};
      7'h37:   r = {3'b100, 8'b0001_0000, iU};
      7'h17:   r = {3'b100, 8'b0001_0000, iU};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] idx, input logic we,
                                           input logic [4:0] wrd, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
    if (we && wrd == idx) return wd;
    return mregs[idx];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic [31:0] ins, input logic fl, input logic exmr,
                       input logic [4:0] exrd, input logic we, input logic [4:0] wrd,
                       input logic [31:0] wd, input logic r);
    ref_t        d;
    logic        haz, live;
    logic [31:0] e1, e2, pc;
    pc = $urandom() & 32'hFFFF_FFFC;
    rst = r; order_data = ins; pc_in_data = pc; plusFour_in_data = pc + 32'd4;
    flush = fl; ex_mem_read = exmr; ex_rd = exrd;
    wb_we = we; wb_rd = wrd; wb_data = wd;
    #1;
    d   = ref_decode(ins);
    e1  = ref_read(ins[19:15], we, wrd, wd);
    e2  = ref_read(ins[24:20], we, wrd, wd);
    haz = exmr && exrd != 5'd0 &&
          ((d.u1 && exrd == ins[19:15]) || (d.u2 && exrd == ins[24:20]));
    exp_stall  = !r && haz && !fl;
    stall_seen = stall;
    chk("stall", 32'(stall), 32'(exp_stall));
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    end else if (we && wrd != 5'd0) begin
      mregs[wrd] = wd;
    end
    live = !r && d.legal && !fl && !haz;
    chk("id_valid", 32'(id_valid), 32'(live));
    chk("illegal", 32'(illegal), 32'(!r && !d.legal && !fl));
    chk("ctrl", 32'(ctrl_obs), live ? 32'(d.ctrl) : 32'd0);
    if (r || live) begin
      chk("rs1_data", rs1_data, r ? 32'd0 : e1);
      chk("rs2_data", rs2_data, r ? 32'd0 : e2);
      chk("imm", imm, r ? 32'd0 : d.imm);
      chk("fields", 32'({rd, rs1, rs2, funct3, funct7b5}),
          r ? 32'd0 : 32'({ins[11:7], ins[19:15], ins[24:20], ins[14:12], ins[30]}));
      chk("pc_out", pc_out_data, r ? 32'd0 : pc);
      chk("plus4_out", plusFour_out_data, r ? 32'd0 : pc + 32'd4);
    end
  endtask

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ADD413 = 32'h0021_8233; // ADD x4,x3,x2

  logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
  logic [31:0] rins;
  logic        hold, rexmr;
  int          k;

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    cycle(NOP, 0, 0, 0, 0, 0, 0, 1);
    cycle(ADD413, 0, 1, 3, 1, 7, 32'h77, 1);
    chk("rst_stall", 32'(stall_seen), 32'd0);

    cycle(NOP, 0, 0, 0, 1, 2, 32'h22, 0);
    cycle(NOP, 0, 0, 0, 1, 3, 32'h33, 0);

    cycle(32'h0002_80B3, 0, 0, 0, 1, 5, 32'hDEAD_BEEF, 0);
    chk("byp_rs1", rs1_data, 32'hDEAD_BEEF);
    chk("byp_rw", 32'(reg_write), 32'd1);

    cycle(NOP, 0, 0, 0, 1, 0, 32'h1234, 0);
    cycle(32'hFFF0_0113, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_rs1", rs1_data, 32'd0);
    chk("x0_imm", imm, 32'hFFFF_FFFF);

    cycle(ADD413, 0, 1, 3, 0, 0, 0, 0);
    chk("lu_stall", 32'(stall_seen), 32'd1);
    chk("lu_bubble", 32'(id_valid), 32'd0);
    cycle(ADD413, 0, 0, 3, 0, 0, 0, 0);
    chk("lu_resume", rs1_data, 32'h33);

    cycle(ADD413, 1, 1, 3, 0, 0, 0, 0);
    chk("fl_stall", 32'(stall_seen), 32'd0);
    chk("fl_rw", 32'(reg_write), 32'd0);

    cycle(32'hFE00_0EE3, 0, 0, 0, 0, 0, 0, 0); // BEQ x0,x0,-4
    chk("beq_imm", imm, 32'hFFFF_FFFC);
    chk("beq_br", 32'(branch), 32'd1);
    cycle(32'h0080_00EF, 0, 0, 0, 0, 0, 0, 0);
    chk("jal_imm", imm, 32'h0000_0008);
    chk("jal_wbsel", 32'(wb_sel), 32'd2);
    cycle(32'h1234_52B7, 0, 0, 0, 0, 0, 0, 0);
    chk("lui_imm", imm, 32'h1234_5000);

    cycle(32'h0000_007F, 0, 0, 0, 0, 0, 0, 0);
    chk("ill_flag", 32'(illegal), 32'd1);

    cycle(ADD413, 0, 1, 3, 0, 0, 0, 0);
    cycle(ADD413, 0, 1, 3, 0, 0, 0, 1);
    chk("midstall_rst", 32'(stall_seen), 32'd0);
    cycle(ADD413, 0, 0, 0, 0, 0, 0, 0);

    hold = 1'b0;
    rins = NOP;
    for (int n = 0; n < 800; n++) begin
      if (!hold) begin
        k    = $urandom_range(0, 9);
        rins = $urandom();
        rins[19:15] = 5'($urandom_range(0, 7));
        rins[24:20] = 5'($urandom_range(0, 7));
        rins[6:0]   = (k == 9) ? 7'($urandom()) : ops[k];
      end
      rexmr = hold ? 1'b0 : ($urandom_range(0, 1) == 1);
      cycle(rins, ($urandom_range(0, 7) == 0), rexmr,
            ($urandom_range(0, 2) == 0) ? rins[19:15] : 5'($urandom_range(0, 7)),
            ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom(),
            ($urandom_range(0, 60) == 0));
      hold = exp_stall;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
